// File: rtl/spi_slave_bmm150_emu.sv
// SPI mode-3 responder emulating the BMM150 register map for hardware-in-the-loop use.
// SCLK/CS_N/MOSI are oversampled in the clk domain; host logic injects measurement bytes.
module spi_slave_bmm150_emu #(
    parameter logic [7:0] CHIP_ID  = 8'h32,
    parameter logic [6:0] RO_LIMIT = 7'h4B,
    parameter int         SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        data_load,
    input  logic [63:0] data_in,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_act
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD,
        ST_WR
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STG-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
    logic                sclk_prev_q, sclk_prev_d;
    logic                cs_prev_q,   cs_prev_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_sr_q,   rx_sr_d;
    logic [7:0]  tx_sr_q,   tx_sr_d;
    logic [6:0]  ptr_q,     ptr_d;
    logic        miso_q,    miso_d;
    logic        wr_valid_q, wr_valid_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [63:0] shadow_q,  shadow_d;
    logic        pend_q,    pend_d;
    logic [7:0]  regs_q [128];
    logic [7:0]  regs_d [128];

    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise, sclk_fall, cs_fall;
    logic [7:0]  rx_byte;
    logic [6:0]  ptr_inc;
    logic        load_en;
    logic [63:0] load_word;

    assign sclk_s    = sclk_sync_q[SYNC_STG-1];
    assign cs_s      = cs_sync_q[SYNC_STG-1];
    assign mosi_s    = mosi_sync_q[SYNC_STG-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign rx_byte   = {rx_sr_q, mosi_s};
    assign ptr_inc   = ptr_q + 7'd1;

    assign miso      = miso_q;
    assign miso_oe   = (state_q == ST_RD);
    assign frame_act = (state_q != ST_IDLE);
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STG-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // Injected data only lands while idle; mid-frame loads wait in the shadow so a
    // burst read never mixes old and new samples. The newest load always wins.
    always_comb begin
        load_en   = 1'b0;
        load_word = data_in;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        if (state_q == ST_IDLE) begin
            if (data_load) begin
                load_en = 1'b1;
                pend_d  = 1'b0;
            end else if (pend_q) begin
                load_en   = 1'b1;
                load_word = shadow_q;
                pend_d    = 1'b0;
            end
        end else if (data_load) begin
            shadow_d = data_in;
            pend_d   = 1'b1;
        end
    end

    // NOTE: every variable assigned in an always_comb gets a default at the top of the
    // block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        ptr_d      = ptr_q;
        miso_d     = miso_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        if (load_en) begin
            regs_d[7'h42] = load_word[63:56];
            regs_d[7'h43] = load_word[55:48];
            regs_d[7'h44] = load_word[47:40];
            regs_d[7'h45] = load_word[39:32];
            regs_d[7'h46] = load_word[31:24];
            regs_d[7'h47] = load_word[23:16];
            regs_d[7'h48] = load_word[15:8];
            regs_d[7'h49] = load_word[7:0];
        end

        if (cs_s) begin
            // Deselect aborts whatever is in flight; a partial byte has no effect.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d = rx_byte[6:0];
                            if (rx_byte[7]) begin
                                tx_sr_d = regs_q[rx_byte[6:0]];
                                state_d = ST_RD;
                            end else begin
                                state_d = ST_WR;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (sclk_fall) begin
                        miso_d    = tx_sr_q[7];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d   = ptr_inc;
                            tx_sr_d = regs_q[ptr_inc];
                        end else begin
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end
                ST_WR: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Applied after the data_load merge so an SPI write wins.
                            if (ptr_q >= RO_LIMIT) begin
                                regs_d[ptr_q] = rx_byte;
                                wr_valid_d    = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_data_d     = rx_byte;
                            end
                            ptr_d = ptr_inc;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 7'd0;
            tx_sr_q     <= 8'd0;
            ptr_q       <= 7'd0;
            miso_q      <= 1'b1;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 8'd0;
            shadow_q    <= 64'd0;
            pend_q      <= 1'b0;
            // NOTE: the register file must come up with defined contents (CHIP_ID in
            // 0x40), so it is built from resettable flops rather than inferred RAM.
            regs_q        <= '{default: 8'h00};
            regs_q[7'h40] <= CHIP_ID;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            ptr_q       <= ptr_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_bmm150_emu.sv
// Directed bench for spi_slave_bmm150_emu: drives mode-3 SPI frames and checks
// read data, write strobes, data_load coherence and frame abort.
module tb_spi_slave_bmm150_emu;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        data_load;
    logic [63:0] data_in;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_act;

    int n_cmp = 0;
    int n_err = 0;

    int         wr_cnt = 0;
    logic [6:0] wr_addr_seen = 7'd0;
    logic [7:0] wr_data_seen = 8'd0;

    spi_slave_bmm150_emu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .data_load (data_load),
        .data_in   (data_in),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_act (frame_act)
    );

    always #5 clk = ~clk;

    // Counts clk cycles with wr_valid high, so a stuck strobe shows up as extra writes.
    always @(posedge clk) begin
        if (wr_valid) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_seen <= wr_addr;
            wr_data_seen <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    // Sends nbits of tx MSB first; miso is captured just before each rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits,
                             output logic [7:0] rx, output logic oe_any, output logic oe_all);
        rx     = 8'd0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            wait_clk(HALF);
            rx[i]  = miso;
            oe_any = oe_any | miso_oe;
            oe_all = oe_all & miso_oe;
            sclk   = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx,
                        output logic oe_any, output logic oe_all);
        xfer_bits(tx, 8, rx, oe_any, oe_all);
    endtask

    task automatic pulse_load(input logic [63:0] word);
        data_in   = word;
        data_load = 1'b1;
        wait_clk(1);
        data_load = 1'b0;
    endtask

    initial begin
        logic [7:0]  rx;
        logic        oe_any;
        logic        oe_all;
        int          wr_base;
        logic [63:0] old_word;
        logic [63:0] new_word;

        old_word  = 64'h1122_3344_5566_7788;
        new_word  = 64'hA1A2_A3A4_A5A6_A7A8;
        rst_n     = 1'b0;
        sclk      = 1'b1;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        data_load = 1'b0;
        data_in   = 64'd0;
        wait_clk(5);

        check("rst_miso", 64'(miso), 64'd1);
        check("rst_miso_oe", 64'(miso_oe), 64'd0);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_frame_act", 64'(frame_act), 64'd0);

        rst_n = 1'b1;
        wait_clk(4);

        // Chip-ID read.
        frame_begin();
        check("frame_act_in_frame", 64'(frame_act), 64'd1);
        xfer(8'hC0, rx, oe_any, oe_all);
        check("chipid_cmd_oe_low", 64'(oe_any), 64'd0);
        xfer(8'h00, rx, oe_any, oe_all);
        check("chipid_data", 64'(rx), 64'h32);
        check("chipid_data_oe_high", 64'(oe_all), 64'd1);
        frame_end();
        check("idle_frame_act", 64'(frame_act), 64'd0);
        check("idle_miso_oe", 64'(miso_oe), 64'd0);
        check("idle_miso", 64'(miso), 64'd1);

        // Writable register: strobe and readback.
        wr_base = wr_cnt;
        frame_begin();
        xfer(8'h4B, rx, oe_any, oe_all);
        xfer(8'h01, rx, oe_any, oe_all);
        frame_end();
        check("wr4b_count", 64'(wr_cnt - wr_base), 64'd1);
        check("wr4b_addr", 64'(wr_addr_seen), 64'h4B);
        check("wr4b_data", 64'(wr_data_seen), 64'h01);
        frame_begin();
        xfer(8'hCB, rx, oe_any, oe_all);
        xfer(8'h00, rx, oe_any, oe_all);
        frame_end();
        check("rd4b_data", 64'(rx), 64'h01);

        // Idle data_load followed by an 8-byte burst.
        pulse_load(old_word);
        wait_clk(2);
        frame_begin();
        xfer(8'hC2, rx, oe_any, oe_all);
        for (int k = 0; k < 8; k++) begin
            xfer(8'h00, rx, oe_any, oe_all);
            check($sformatf("burst_old_%0d", k), 64'(rx), 64'(old_word[63-8*k -: 8]));
        end
        frame_end();

        // Loads during a burst stay hidden until the frame ends; the newest load wins.
        frame_begin();
        xfer(8'hC2, rx, oe_any, oe_all);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                pulse_load(64'hDEAD_BEEF_0000_0001);
                pulse_load(new_word);
            end
            xfer(8'h00, rx, oe_any, oe_all);
            check($sformatf("coherent_old_%0d", k), 64'(rx), 64'(old_word[63-8*k -: 8]));
        end
        frame_end();
        frame_begin();
        xfer(8'hC2, rx, oe_any, oe_all);
        for (int k = 0; k < 8; k++) begin
            xfer(8'h00, rx, oe_any, oe_all);
            check($sformatf("burst_new_%0d", k), 64'(rx), 64'(new_word[63-8*k -: 8]));
        end
        frame_end();

        // Read-only write is dropped silently.
        wr_base = wr_cnt;
        frame_begin();
        xfer(8'h42, rx, oe_any, oe_all);
        xfer(8'hFF, rx, oe_any, oe_all);
        frame_end();
        check("ro_wr_count", 64'(wr_cnt - wr_base), 64'd0);
        frame_begin();
        xfer(8'hC2, rx, oe_any, oe_all);
        xfer(8'h00, rx, oe_any, oe_all);
        frame_end();
        check("ro_readback", 64'(rx), 64'hA1);

        // Write burst across the wrap: 0x7F accepted, 0x00 is read-only.
        wr_base = wr_cnt;
        frame_begin();
        xfer(8'h7F, rx, oe_any, oe_all);
        xfer(8'h5A, rx, oe_any, oe_all);
        xfer(8'h77, rx, oe_any, oe_all);
        frame_end();
        check("wrap_wr_count", 64'(wr_cnt - wr_base), 64'd1);
        check("wrap_wr_addr", 64'(wr_addr_seen), 64'h7F);
        check("wrap_wr_data", 64'(wr_data_seen), 64'h5A);
        frame_begin();
        xfer(8'hFF, rx, oe_any, oe_all);
        xfer(8'h00, rx, oe_any, oe_all);
        check("wrap_rd_7f", 64'(rx), 64'h5A);
        xfer(8'h00, rx, oe_any, oe_all);
        check("wrap_rd_00", 64'(rx), 64'h00);
        frame_end();

        // Deselect after half a data byte: no write, back to idle, next frame works.
        wr_base = wr_cnt;
        frame_begin();
        xfer(8'h50, rx, oe_any, oe_all);
        xfer_bits(8'hA0, 4, rx, oe_any, oe_all);
        frame_end();
        check("abort_wr_count", 64'(wr_cnt - wr_base), 64'd0);
        check("abort_frame_act", 64'(frame_act), 64'd0);
        check("abort_miso", 64'(miso), 64'd1);
        frame_begin();
        xfer(8'hD0, rx, oe_any, oe_all);
        xfer(8'h00, rx, oe_any, oe_all);
        frame_end();
        check("abort_readback", 64'(rx), 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
